// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: opcode/funct codes, loader request op codes,
// loader FSM states and field-packing helpers.
package mips_isa_pkg;

  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
  localparam logic [5:0] OPCODE_LW    = 6'b100011;
  localparam logic [5:0] OPCODE_SW    = 6'b101011;
  localparam logic [5:0] OPCODE_BEQ   = 6'b000100;
  localparam logic [5:0] OPCODE_ADDI  = 6'b001000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [3:0] {
    IOP_ADD  = 4'd0,
    IOP_SUB  = 4'd1,
    IOP_AND  = 4'd2,
    IOP_OR   = 4'd3,
    IOP_SLT  = 4'd4,
    IOP_LW   = 4'd5,
    IOP_SW   = 4'd6,
    IOP_BEQ  = 4'd7,
    IOP_ADDI = 4'd8
  } instr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } loader_state_e;

  function automatic logic [31:0] pack_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [5:0] funct);
    pack_rtype = {OPCODE_RTYPE, rs, rt, rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] pack_itype(input logic [5:0] opcode, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [15:0] imm);
    pack_itype = {opcode, rs, rt, imm};
  endfunction

endpackage

// File: rtl/mips_instr_encode.sv
// Combinational encoder: request op and fields to a 32-bit MIPS word.
// Unknown ops yield a zero word with illegal raised.
module mips_instr_encode
  import mips_isa_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  // select encoding format and code per op
  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    case (op)
      IOP_ADD:  word = pack_rtype(rs, rt, rd, FUNCT_ADD);
      IOP_SUB:  word = pack_rtype(rs, rt, rd, FUNCT_SUB);
      IOP_AND:  word = pack_rtype(rs, rt, rd, FUNCT_AND);
      IOP_OR:   word = pack_rtype(rs, rt, rd, FUNCT_OR);
      IOP_SLT:  word = pack_rtype(rs, rt, rd, FUNCT_SLT);
      IOP_LW:   word = pack_itype(OPCODE_LW,   rs, rt, imm);
      IOP_SW:   word = pack_itype(OPCODE_SW,   rs, rt, imm);
      IOP_BEQ:  word = pack_itype(OPCODE_BEQ,  rs, rt, imm);
      IOP_ADDI: word = pack_itype(OPCODE_ADDI, rs, rt, imm);
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_loader.sv
// Instruction loader: accepts encoded-instruction requests over valid/ready
// and writes them to consecutive instruction memory words via a register stage.
module mips_instr_loader
  import mips_isa_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [1:0]        err
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0] enc_word_s;
  logic        enc_illegal_s;
  logic        last_addr_s;

  mips_instr_encode u_encode (
    .op      (in_op),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm     (in_imm),
    .word    (enc_word_s),
    .illegal (enc_illegal_s)
  );

  assign last_addr_s = (ptr_q == ADDR_W'(DEPTH - 1));

  // next-state, pointer/count/error update and output-stage load
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          count_d = '0;
          err_d   = 2'b00;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // start wins over a request presented in the same cycle
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          count_d = '0;
          err_d   = 2'b00;
        end else if (in_valid) begin
          if (enc_illegal_s) begin
            err_d[0] = 1'b1;
            if (in_last) begin
              state_d = ST_FLUSH;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = enc_word_s;
            count_d = count_q + (ADDR_W + 1)'(1);
            ptr_d   = last_addr_s ? ptr_q : ptr_q + ADDR_W'(1);
            if (in_last) begin
              state_d = ST_FLUSH;
            end else if (last_addr_s) begin
              state_d  = ST_FLUSH;
              err_d[1] = 1'b1;
            end else begin
              state_d = ST_LOAD;
            end
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          count_d = '0;
          err_d   = 2'b00;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state, pointer and output-stage registers; reset drops any in-flight write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 2'b00;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FLUSH);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mips_instr_loader.sv
// Directed bench for mips_instr_loader (DEPTH=4) with a write scoreboard.
module tb_mips_instr_loader;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n, start, in_valid, in_last;
  logic [3:0]        in_op;
  logic [4:0]        in_rs, in_rt, in_rd;
  logic [15:0]       in_imm;
  logic              in_ready, imem_we, busy, done;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic [1:0]        err;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int exp_ptr  = 0;
  int d0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  mips_instr_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [15:0] imm);
    case (op)
      4'd0: enc = {6'h00, rs, rt, rd, 5'h00, 6'h20};
      4'd1: enc = {6'h00, rs, rt, rd, 5'h00, 6'h22};
      4'd2: enc = {6'h00, rs, rt, rd, 5'h00, 6'h24};
      4'd3: enc = {6'h00, rs, rt, rd, 5'h00, 6'h25};
      4'd4: enc = {6'h00, rs, rt, rd, 5'h00, 6'h2A};
      4'd5: enc = {6'h23, rs, rt, imm};
      4'd6: enc = {6'h2B, rs, rt, imm};
      4'd7: enc = {6'h04, rs, rt, imm};
      4'd8: enc = {6'h08, rs, rt, imm};
      default: enc = 32'h0;
    endcase
  endfunction

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (imem_we !== 1'b0) begin
      chk("write_expected", {31'd0, exp_addr_q.size() != 0}, 32'd1);
      if (exp_addr_q.size() != 0) begin
        chk("wr_addr", {30'd0, imem_addr}, exp_addr_q.pop_front());
        chk("wr_data", imem_wdata, exp_data_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    exp_ptr = 0;
  endtask

  // Present one request for one cycle; exp_acc is whether it should be taken.
  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic last,
                      input logic legal, input logic exp_acc, input logic [31:0] word);
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_last = last;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_acc});
    if (exp_acc && legal) begin
      exp_addr_q.push_back(32'(exp_ptr));
      exp_data_q.push_back(word);
    end
    @(posedge clk); #1;
    if (exp_acc && legal) begin
      chk("lat_we", {31'd0, imem_we}, 32'd1);
      chk("lat_addr", {30'd0, imem_addr}, 32'(exp_ptr));
      exp_ptr++;
    end else begin
      chk("no_we", {31'd0, imem_we}, 32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_we"},       {31'd0, imem_we},  32'd0);
    chk({tag, "_addr"},     {30'd0, imem_addr}, 32'd0);
    chk({tag, "_wdata"},    imem_wdata,        32'd0);
    chk({tag, "_busy"},     {31'd0, busy},     32'd0);
    chk({tag, "_done"},     {31'd0, done},     32'd0);
    chk({tag, "_count"},    {29'd0, count},    32'd0);
    chk({tag, "_err"},      {30'd0, err},      32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single ADD with last
    do_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    d0 = done_cnt;
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 1'b1, 1'b1, 1'b1, 32'h0022_1820);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_count", {29'd0, count}, 32'd1);
    chk("t1_err", {30'd0, err}, 32'd0);
    @(posedge clk); #1;
    chk("t1_done_low", {31'd0, done}, 32'd0);
    chk("t1_idle", {31'd0, busy}, 32'd0);
    chk("t1_count_hold", {29'd0, count}, 32'd1);
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);

    // back-to-back stream
    do_start();
    send(4'd5, 5'd0, 5'd8, 5'd0, 16'h0004, 1'b0, 1'b1, 1'b1, 32'h8C08_0004);
    send(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 1'b0, 1'b1, 1'b1, 32'h1022_FFFF);
    send(4'd8, 5'd0, 5'd1, 5'd0, 16'h0005, 1'b1, 1'b1, 1'b1, 32'h2001_0005);
    chk("t2_count", {29'd0, count}, 32'd3);
    chk("t2_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;

    // illegal op between legal ones
    do_start();
    send(4'd0, 5'd4, 5'd5, 5'd6, 16'd0, 1'b0, 1'b1, 1'b1, enc(4'd0, 5'd4, 5'd5, 5'd6, 16'd0));
    send(4'd12, 5'd1, 5'd1, 5'd1, 16'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    chk("t3_err_early", {30'd0, err}, 32'd1);
    send(4'd1, 5'd7, 5'd8, 5'd9, 16'd0, 1'b1, 1'b1, 1'b1, enc(4'd1, 5'd7, 5'd8, 5'd9, 16'd0));
    chk("t3_err", {30'd0, err}, 32'd1);
    chk("t3_count", {29'd0, count}, 32'd2);
    @(posedge clk); #1;

    // overflow at DEPTH without last
    do_start();
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) begin
      send(4'd3, 5'(i), 5'(i + 1), 5'(i + 2), 16'd0, 1'b0, 1'b1, (i < 4) ? 1'b1 : 1'b0,
           enc(4'd3, 5'(i), 5'(i + 1), 5'(i + 2), 16'd0));
    end
    chk("t4_err", {30'd0, err}, 32'd2);
    chk("t4_count", {29'd0, count}, 32'd4);
    chk("t4_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t4_idle", {31'd0, busy}, 32'd0);

    // restart mid-session
    do_start();
    send(4'd2, 5'd1, 5'd2, 5'd3, 16'd0, 1'b0, 1'b1, 1'b1, enc(4'd2, 5'd1, 5'd2, 5'd3, 16'd0));
    send(4'd15, 5'd0, 5'd0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    send(4'd4, 5'd9, 5'd10, 5'd11, 16'd0, 1'b0, 1'b1, 1'b1, enc(4'd4, 5'd9, 5'd10, 5'd11, 16'd0));
    chk("t5_err_pre", {30'd0, err}, 32'd1);
    do_start();
    chk("t5_count_clr", {29'd0, count}, 32'd0);
    chk("t5_err_clr", {30'd0, err}, 32'd0);
    send(4'd6, 5'd3, 5'd4, 5'd0, 16'h0010, 1'b1, 1'b1, 1'b1, enc(4'd6, 5'd3, 5'd4, 5'd0, 16'h0010));
    chk("t5_count", {29'd0, count}, 32'd1);
    @(posedge clk); #1;

    // reset right after an accept, then in_valid while idle
    do_start();
    in_valid = 1'b1; in_op = 4'd0; in_rs = 5'd1; in_rt = 5'd1; in_rd = 5'd1; in_last = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    chk("midrst_no_we", {31'd0, imem_we}, 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle_no_we", {31'd0, imem_we}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_addr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
